// File: rtl/pet2001_pkg.sv
// Shared constants and FSM encoding for the PET 2001 video RAM arbiter.
package pet2001_pkg;

    localparam int RAM_AW       = 11;
    localparam int RAM_DW       = 8;
    localparam int MAX_WAIT_DEF = 7;
    localparam int WAIT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VID  = 2'd1,
        CPU  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/pet2001_vram_arb.sv
// Shares the single-port PET video RAM between video fetch and the CPU,
// video first, with a bounded-wait override for a starving CPU.
module pet2001_vram_arb
    import pet2001_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce_7mp,
    input  logic              vid_req,
    input  logic [RAM_AW-1:0] vid_addr,
    output logic [RAM_DW-1:0] vid_data,
    output logic              vid_valid,
    output logic              vid_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [RAM_DW-1:0] cpu_wdata,
    output logic [RAM_DW-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [RAM_DW-1:0] ram_wdata,
    input  logic [RAM_DW-1:0] ram_q
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    arb_state_t        state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic              miss_pend, miss_pend_nx;
    logic              cpu_elig, vid_win, cpu_win;

    logic [RAM_DW-1:0] vid_data_nx, cpu_rdata_nx, ram_wdata_nx;
    logic [RAM_AW-1:0] ram_addr_nx;
    logic              vid_valid_nx, vid_miss_nx, cpu_ack_nx, ram_we_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            miss_pend <= 1'b0;
            vid_data  <= '0;
            vid_valid <= 1'b0;
            vid_miss  <= 1'b0;
            cpu_rdata <= '0;
            cpu_ack   <= 1'b0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_nx;
            miss_pend <= miss_pend_nx;
            vid_data  <= vid_data_nx;
            vid_valid <= vid_valid_nx;
            vid_miss  <= vid_miss_nx;
            cpu_rdata <= cpu_rdata_nx;
            cpu_ack   <= cpu_ack_nx;
            ram_addr  <= ram_addr_nx;
            ram_we    <= ram_we_nx;
            ram_wdata <= ram_wdata_nx;
        end
    end

    // The just-acked CPU request is not eligible, so it cannot be re-granted.
    always_comb begin
        cpu_elig = cpu_req && (state != CPU);
        vid_win  = vid_req && (!cpu_elig || (wait_cnt < WAIT_MAX));
        cpu_win  = !vid_win && cpu_elig;
    end

    always_comb begin
        state_nx     = state;
        wait_nx      = wait_cnt;
        miss_pend_nx = miss_pend;
        vid_data_nx  = vid_data;
        vid_valid_nx = 1'b0;
        vid_miss_nx  = 1'b0;
        cpu_rdata_nx = cpu_rdata;
        cpu_ack_nx   = 1'b0;
        ram_addr_nx  = ram_addr;
        ram_we_nx    = ram_we;
        ram_wdata_nx = ram_wdata;

        if (ce_7mp) begin
            unique case (state)
                VID: begin
                    vid_data_nx  = ram_q;
                    vid_valid_nx = 1'b1;
                end
                CPU: begin
                    cpu_ack_nx  = 1'b1;
                    vid_miss_nx = miss_pend;
                    if (!ram_we)
                        cpu_rdata_nx = ram_q;
                end
                default: ;
            endcase

            miss_pend_nx = cpu_win && vid_req;

            if (cpu_win || !cpu_req)
                wait_nx = '0;
            else if (cpu_elig && (wait_cnt < WAIT_MAX))
                wait_nx = wait_cnt + WAIT_W'(1);

            unique case (1'b1)
                vid_win: begin
                    state_nx    = VID;
                    ram_addr_nx = vid_addr;
                    ram_we_nx   = 1'b0;
                end
                cpu_win: begin
                    state_nx     = CPU;
                    ram_addr_nx  = cpu_addr;
                    ram_we_nx    = cpu_we;
                    ram_wdata_nx = cpu_wdata;
                end
                default: begin
                    state_nx  = IDLE;
                    ram_we_nx = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pet2001_vram_arb.sv
// Directed bench for pet2001_vram_arb with a synchronous RAM model.
module tb_pet2001_vram_arb;
    import pet2001_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_7mp = 1'b0;
    logic        vid_req = 1'b0;
    logic [10:0] vid_addr = '0;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        vid_miss;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [10:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_q = '0;

    logic [7:0]  mem [0:2047];
    logic        preload = 1'b1;

    int n_run  = 0;
    int n_fail = 0;

    logic c_vv, c_vm, c_ack;

    pet2001_vram_arb #(.MAX_WAIT(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce_7mp    (ce_7mp),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_valid (vid_valid),
        .vid_miss  (vid_miss),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_q     (ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 2048; i++)
                mem[i] <= 8'(i);
        end else begin
            if (ram_we)
                mem[ram_addr] <= ram_wdata;
            ram_q <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One tick: ce high for one edge, then one idle edge; pulses captured
    // on the negedge right after the tick edge.
    task automatic tick();
        @(negedge clk);
        ce_7mp = 1'b1;
        @(negedge clk);
        ce_7mp = 1'b0;
        c_vv  = vid_valid;
        c_vm  = vid_miss;
        c_ack = cpu_ack;
        @(negedge clk);
    endtask

    task automatic chk_pulses(input string tag, input logic vv,
                              input logic vm, input logic ack);
        chk({tag, "_vv"},  32'(c_vv),  32'(vv));
        chk({tag, "_vm"},  32'(c_vm),  32'(vm));
        chk({tag, "_ack"}, 32'(c_ack), 32'(ack));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vdata"}, 32'(vid_data),  0);
        chk({tag, "_vv"},    32'(vid_valid), 0);
        chk({tag, "_vm"},    32'(vid_miss),  0);
        chk({tag, "_rdata"}, 32'(cpu_rdata), 0);
        chk({tag, "_ack"},   32'(cpu_ack),   0);
        chk({tag, "_raddr"}, 32'(ram_addr),  0);
        chk({tag, "_we"},    32'(ram_we),    0);
        chk({tag, "_wdata"}, 32'(ram_wdata), 0);
        chk({tag, "_state"}, 32'(dut.state), 32'(IDLE));
        chk({tag, "_wait"},  32'(dut.wait_cnt), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        preload = 1'b0;
        chk_all_zero("rst");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        cpu_req = 1; cpu_we = 1; cpu_addr = 11'h123; cpu_wdata = 8'h5A;
        tick();
        chk_pulses("wr_grant", 0, 0, 0);
        chk("wr_we",    32'(ram_we),    1);
        chk("wr_addr",  32'(ram_addr),  32'h123);
        chk("wr_wdata", 32'(ram_wdata), 32'h5A);
        tick();
        chk_pulses("wr_done", 0, 0, 1);
        chk("wr_we_off", 32'(ram_we),    0);
        chk("wr_state",  32'(dut.state), 32'(IDLE));
        cpu_req = 0; cpu_we = 0;
        tick();
        chk("wr_nodup", 32'(dut.state), 32'(IDLE));

        cpu_req = 1;
        tick();
        chk_pulses("rd_grant", 0, 0, 0);
        chk("rd_we", 32'(ram_we), 0);
        tick();
        chk_pulses("rd_done", 0, 0, 1);
        chk("rd_data", 32'(cpu_rdata), 32'h5A);
        chk("rd_ack_gone", 32'(cpu_ack), 0);
        cpu_req = 0;

        for (int i = 0; i < 40; i++) begin
            vid_req = 1; vid_addr = 11'(i);
            tick();
            chk("vf_req_vv", 32'(c_vv), 0);
            vid_req = 0;
            tick();
            chk_pulses("vf_done", 1, 0, 0);
            chk("vf_data", 32'(vid_data), 32'(i));
            repeat (6) tick();
        end

        repeat (10) @(negedge clk);
        chk("hold_vdata", 32'(vid_data),  32'h27);
        chk("hold_vv",    32'(vid_valid), 0);

        vid_req = 1; vid_addr = 11'h005;
        cpu_req = 1; cpu_we = 0; cpu_addr = 11'h123;
        tick();
        chk_pulses("sim_t1", 0, 0, 0);
        chk("sim_state1", 32'(dut.state), 32'(VID));
        vid_req = 0;
        tick();
        chk_pulses("sim_t2", 1, 0, 0);
        chk("sim_vdata", 32'(vid_data), 32'h05);
        tick();
        chk_pulses("sim_t3", 0, 0, 1);
        chk("sim_rdata", 32'(cpu_rdata), 32'h5A);
        cpu_req = 0;
        tick();

        vid_req = 1; vid_addr = 11'h010;
        cpu_req = 1; cpu_we = 0; cpu_addr = 11'h007;
        tick();
        chk_pulses("st_t1", 0, 0, 0);
        tick();
        chk_pulses("st_t2", 1, 0, 0);
        chk("st_vdata", 32'(vid_data), 32'h10);
        tick();
        chk_pulses("st_t3", 1, 0, 0);
        chk("st_wait3", 32'(dut.wait_cnt), 3);
        tick();
        chk_pulses("st_t4", 1, 0, 0);
        chk("st_state4", 32'(dut.state),    32'(CPU));
        chk("st_wait4",  32'(dut.wait_cnt), 0);
        tick();
        chk_pulses("st_t5", 0, 1, 1);
        chk("st_rdata",  32'(cpu_rdata), 32'h07);
        chk("st_state5", 32'(dut.state), 32'(VID));
        cpu_req = 0;
        tick();
        chk_pulses("st_t6", 1, 0, 0);
        vid_req = 0;
        tick();
        chk_pulses("st_t7", 1, 0, 0);
        chk("st_state7", 32'(dut.state), 32'(IDLE));

        cpu_req = 1; cpu_we = 1; cpu_addr = 11'h200; cpu_wdata = 8'hA5;
        tick();
        chk("rs_we_on", 32'(ram_we), 1);
        #2 reset_n = 1'b0;
        #1 chk("rs_we_drop", 32'(ram_we), 0);
        cpu_req = 0; cpu_we = 0;
        tick();
        chk("rs_noack", 32'(c_ack), 0);
        reset_n = 1'b1;
        chk_all_zero("rs_rel");
        tick();
        chk_pulses("rs_after", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
